// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: Wishbone master that drives the iicmb_m_wb I2C core.
// Turns single-byte read/write requests into CSR/DPR/CMDR command sequences.
module i2c_txn_sequencer #(
    parameter int NUM_BUSSES     = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rnw_i,
    input  logic [7:0] req_bus_id_i,
    input  logic [6:0] req_addr_i,
    input  logic [7:0] req_data_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_nak_o,
    output logic       rsp_err_o,
    output logic       cyc_o,
    output logic       stb_o,
    output logic       we_o,
    output logic [1:0] adr_o,
    output logic [7:0] dat_o,
    input  logic [7:0] dat_i,
    input  logic       ack_i,
    input  logic       irq_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] A_CSR  = 2'd0;
    localparam logic [1:0] A_DPR  = 2'd1;
    localparam logic [1:0] A_CMDR = 2'd2;

    localparam logic [2:0] C_SET_BUS = 3'b110;
    localparam logic [2:0] C_START   = 3'b100;
    localparam logic [2:0] C_WRITE   = 3'b001;
    localparam logic [2:0] C_RD_NACK = 3'b011;
    localparam logic [2:0] C_STOP    = 3'b101;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_DPR_WR,
        S_CMD_WR,
        S_WAIT_IRQ,
        S_STAT_RD,
        S_DATA_RD,
        S_RESP
    } state_t;

    // Which core command the current CMDR write / status read belongs to.
    typedef enum logic [2:0] {
        P_SET_BUS,
        P_START,
        P_ADDR,
        P_DATA,
        P_READ,
        P_STOP
    } phase_t;

    state_t          state;
    phase_t          phase;
    logic            rnw;
    logic [7:0]      bus_id;
    logic [6:0]      addr;
    logic [7:0]      wdata;
    logic [7:0]      dpr;
    logic [7:0]      last_bus;
    logic            bus_valid;
    logic [CW-1:0]   cnt;
    logic            bus_ok;

    // An out-of-range bus can never be selected, so never cache it.
    assign bus_ok = (int'(bus_id) < NUM_BUSSES);

    function automatic logic [2:0] cmd_of(input phase_t p);
        logic [2:0] c;
        c = C_STOP;
        case (p)
            P_SET_BUS: c = C_SET_BUS;
            P_START:   c = C_START;
            P_ADDR:    c = C_WRITE;
            P_DATA:    c = C_WRITE;
            P_READ:    c = C_RD_NACK;
            default:   c = C_STOP;
        endcase
        return c;
    endfunction

    // Main sequencer: WB op engine, command sequencing and response generation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_INIT;
            phase       <= P_SET_BUS;
            rnw         <= 1'b0;
            bus_id      <= 8'h00;
            addr        <= 7'h00;
            wdata       <= 8'h00;
            dpr         <= 8'h00;
            last_bus    <= 8'h00;
            bus_valid   <= 1'b0;
            cnt         <= '0;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= 8'h00;
            rsp_nak_o   <= 1'b0;
            rsp_err_o   <= 1'b0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= 2'd0;
            dat_o       <= 8'h00;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                S_INIT: begin
                    if (!cyc_o) begin
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        we_o  <= 1'b1;
                        adr_o <= A_CSR;
                        dat_o <= 8'hC0;
                    end else if (ack_i) begin
                        cyc_o       <= 1'b0;
                        stb_o       <= 1'b0;
                        we_o        <= 1'b0;
                        adr_o       <= 2'd0;
                        dat_o       <= 8'h00;
                        req_ready_o <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        rnw         <= req_rnw_i;
                        bus_id      <= req_bus_id_i;
                        addr        <= req_addr_i;
                        wdata       <= req_data_i;
                        rsp_data_o  <= 8'h00;
                        rsp_nak_o   <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        if (!bus_valid || req_bus_id_i != last_bus) begin
                            phase <= P_SET_BUS;
                            dpr   <= req_bus_id_i;
                            state <= S_DPR_WR;
                        end else begin
                            phase <= P_START;
                            state <= S_CMD_WR;
                        end
                    end
                end
                S_DPR_WR: begin
                    if (!cyc_o) begin
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        we_o  <= 1'b1;
                        adr_o <= A_DPR;
                        dat_o <= dpr;
                    end else if (ack_i) begin
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        we_o  <= 1'b0;
                        adr_o <= 2'd0;
                        dat_o <= 8'h00;
                        state <= S_CMD_WR;
                    end
                end
                S_CMD_WR: begin
                    if (!cyc_o) begin
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        we_o  <= 1'b1;
                        adr_o <= A_CMDR;
                        dat_o <= {5'b00000, cmd_of(phase)};
                    end else if (ack_i) begin
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        we_o  <= 1'b0;
                        adr_o <= 2'd0;
                        dat_o <= 8'h00;
                        cnt   <= '0;
                        state <= S_WAIT_IRQ;
                    end
                end
                S_WAIT_IRQ: begin
                    if (irq_i) begin
                        state <= S_STAT_RD;
                    end else if (cnt == CNT_LAST) begin
                        rsp_err_o   <= 1'b1;
                        rsp_nak_o   <= 1'b0;
                        rsp_data_o  <= 8'h00;
                        bus_valid   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STAT_RD: begin
                    if (!cyc_o) begin
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        we_o  <= 1'b0;
                        adr_o <= A_CMDR;
                        dat_o <= 8'h00;
                    end else if (ack_i) begin
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        adr_o <= 2'd0;
                        if (dat_i[5] || dat_i[4]) begin
                            rsp_err_o   <= 1'b1;
                            rsp_nak_o   <= 1'b0;
                            rsp_data_o  <= 8'h00;
                            bus_valid   <= 1'b0;
                            rsp_valid_o <= 1'b1;
                            state       <= S_RESP;
                        end else if (dat_i[6] &&
                                     (phase == P_ADDR ||
                                      phase == P_DATA)) begin
                            rsp_nak_o <= 1'b1;
                            phase     <= P_STOP;
                            state     <= S_CMD_WR;
                        end else if (dat_i[7]) begin
                            case (phase)
                                P_SET_BUS: begin
                                    last_bus  <= bus_id;
                                    bus_valid <= bus_ok;
                                    phase     <= P_START;
                                    state     <= S_CMD_WR;
                                end
                                P_START: begin
                                    dpr   <= {addr, rnw};
                                    phase <= P_ADDR;
                                    state <= S_DPR_WR;
                                end
                                P_ADDR: begin
                                    if (rnw) begin
                                        phase <= P_READ;
                                        state <= S_CMD_WR;
                                    end else begin
                                        dpr   <= wdata;
                                        phase <= P_DATA;
                                        state <= S_DPR_WR;
                                    end
                                end
                                P_DATA: begin
                                    phase <= P_STOP;
                                    state <= S_CMD_WR;
                                end
                                P_READ: begin
                                    state <= S_DATA_RD;
                                end
                                default: begin
                                    rsp_valid_o <= 1'b1;
                                    state       <= S_RESP;
                                end
                            endcase
                        end else begin
                            // irq without any completion bit: treat as core failure
                            rsp_err_o   <= 1'b1;
                            rsp_nak_o   <= 1'b0;
                            rsp_data_o  <= 8'h00;
                            bus_valid   <= 1'b0;
                            rsp_valid_o <= 1'b1;
                            state       <= S_RESP;
                        end
                    end
                end
                S_DATA_RD: begin
                    if (!cyc_o) begin
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        we_o  <= 1'b0;
                        adr_o <= A_DPR;
                        dat_o <= 8'h00;
                    end else if (ack_i) begin
                        cyc_o      <= 1'b0;
                        stb_o      <= 1'b0;
                        adr_o      <= 2'd0;
                        rsp_data_o <= dat_i;
                        phase      <= P_STOP;
                        state      <= S_CMD_WR;
                    end
                end
                S_RESP: begin
                    if (rsp_err_o) begin
                        state <= S_INIT;
                    end else begin
                        req_ready_o <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: directed bench with a small iicmb core model.
// Expected WB ops and responses are queued; negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_i2c_txn_sequencer;

    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rnw = 1'b0;
    logic [7:0] req_bus_id = 8'h00;
    logic [6:0] req_addr = 7'h00;
    logic [7:0] req_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_nak;
    logic       rsp_err;
    logic       cyc, stb, we;
    logic [1:0] adr;
    logic [7:0] dat_o;
    logic [7:0] dat_i = 8'h00;
    logic       ack = 1'b0;
    logic       irq = 1'b0;

    i2c_txn_sequencer #(
        .NUM_BUSSES(2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_rnw_i(req_rnw),
        .req_bus_id_i(req_bus_id),
        .req_addr_i(req_addr),
        .req_data_i(req_data),
        .rsp_valid_o(rsp_valid),
        .rsp_data_o(rsp_data),
        .rsp_nak_o(rsp_nak),
        .rsp_err_o(rsp_err),
        .cyc_o(cyc),
        .stb_o(stb),
        .we_o(we),
        .adr_o(adr),
        .dat_o(dat_o),
        .dat_i(dat_i),
        .ack_i(ack),
        .irq_i(irq)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [10:0] exp_ops[$];
    logic [9:0]  exp_rsp[$];
    int rsp_seen = 0;
    int rsp_target = 0;
    int ops_seen = 0;
    int cycle = 0;
    int start_ack_cyc = 0;
    int rsp_cyc = 0;
    logic hang_start = 1'b0;
    logic data_cmd_seen = 1'b0;

    logic [7:0] m_dpr = 8'h00;
    logic [7:0] m_csr = 8'h00;
    logic [7:0] m_status = 8'h00;
    logic       m_pend = 1'b0;
    logic       m_addr_phase = 1'b0;
    int         m_delay = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_w(input logic [1:0] a, input logic [7:0] d);
        exp_ops.push_back({1'b1, a, d});
    endtask

    task automatic push_r(input logic [1:0] a);
        exp_ops.push_back({1'b0, a, 8'h00});
    endtask

    task automatic push_cmd(input logic [2:0] c);
        push_w(2'd2, {5'b00000, c});
        push_r(2'd2);
    endtask

    task automatic push_rsp(input logic [7:0] d, input logic n, input logic e);
        exp_rsp.push_back({d, n, e});
        rsp_target++;
    endtask

    task automatic model_cmd(input logic [2:0] c);
        m_pend  = 1'b1;
        m_delay = 3;
        case (c)
            3'b110: m_status = (m_dpr < 8'd2) ? 8'h80 : 8'h10;
            3'b100: begin
                m_status     = 8'h80;
                m_addr_phase = 1'b1;
                if (hang_start) begin
                    m_pend        = 1'b0;
                    start_ack_cyc = cycle;
                end
            end
            3'b001: begin
                if (m_addr_phase) begin
                    m_addr_phase = 1'b0;
                    m_status = (m_dpr[7:1] == 7'h22 || m_dpr[7:1] == 7'h44)
                             ? 8'h80 : 8'h40;
                end else begin
                    m_status      = 8'h80;
                    data_cmd_seen = 1'b1;
                end
            end
            3'b011: begin
                m_dpr    = 8'hAB;
                m_status = 8'h80;
            end
            3'b101: m_status = 8'h80;
            default: m_status = 8'h10;
        endcase
    endtask

    // Core model plus WB-op and response monitors.
    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            ack          = 1'b0;
            irq          = 1'b0;
            m_pend       = 1'b0;
            m_addr_phase = 1'b0;
            dat_i        = 8'h00;
        end else begin
            if (m_pend) begin
                if (m_delay == 0) begin
                    m_pend = 1'b0;
                    irq    = 1'b1;
                end else begin
                    m_delay--;
                end
            end
            if (ack) begin
                ack = 1'b0;
            end else if (cyc && stb) begin
                ack = 1'b1;
                ops_seen++;
                if (exp_ops.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL wb_unexpected: got we=%b adr=%0d dat=%h expected none",
                             we, adr, dat_o);
                end else begin
                    check("wb_op", {21'd0, we, adr, we ? dat_o : 8'h00},
                          {21'd0, exp_ops.pop_front()});
                end
                if (we) begin
                    case (adr)
                        2'd0: m_csr = dat_o;
                        2'd1: m_dpr = dat_o;
                        2'd2: model_cmd(dat_o[2:0]);
                        default: ;
                    endcase
                end else begin
                    dat_i = (adr == 2'd2) ? m_status : m_dpr;
                    if (adr == 2'd2) irq = 1'b0;
                end
            end
            if (rsp_valid) begin
                rsp_seen++;
                rsp_cyc = cycle;
                if (exp_rsp.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rsp_unexpected: got data=%h nak=%b err=%b expected none",
                             rsp_data, rsp_nak, rsp_err);
                end else begin
                    check("rsp", {22'd0, rsp_data, rsp_nak, rsp_err},
                          {22'd0, exp_rsp.pop_front()});
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got ready=0 expected 1");
        end
    endtask

    task automatic do_req(input logic rnw, input logic [7:0] bus,
                          input logic [6:0] a, input logic [7:0] d);
        wait_ready();
        req_rnw    = rnw;
        req_bus_id = bus;
        req_addr   = a;
        req_data   = d;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("ready_drop", {31'd0, req_ready}, 32'd0);
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (rsp_seen < rsp_target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (rsp_seen < rsp_target) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_timeout: got %0d rsps expected %0d",
                     rsp_seen, rsp_target);
        end
    endtask

    task automatic full_write(input logic [7:0] bus, input logic [6:0] a,
                              input logic [7:0] d, input logic setbus);
        if (setbus) begin
            push_w(2'd1, bus);
            push_cmd(3'b110);
        end
        push_cmd(3'b100);
        push_w(2'd1, {a, 1'b0});
        push_cmd(3'b001);
        push_w(2'd1, d);
        push_cmd(3'b001);
        push_cmd(3'b101);
        push_rsp(8'h00, 1'b0, 1'b0);
        do_req(1'b0, bus, a, d);
        wait_rsp();
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs",
              {7'd0, cyc, stb, we, adr, dat_o, req_ready, rsp_valid,
               rsp_data, rsp_nak, rsp_err}, 32'd0);
        push_w(2'd0, 8'hC0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_after_csr", {31'd0, req_ready}, 32'd1);
        check("ops_before_ready", ops_seen, 1);

        full_write(8'd0, 7'h22, 8'h78, 1'b1);
        full_write(8'd0, 7'h22, 8'h78, 1'b0);

        push_cmd(3'b100);
        push_w(2'd1, 8'h89);
        push_cmd(3'b001);
        push_cmd(3'b011);
        push_r(2'd1);
        push_cmd(3'b101);
        push_rsp(8'hAB, 1'b0, 1'b0);
        do_req(1'b1, 8'd0, 7'h44, 8'h00);
        wait_rsp();

        push_cmd(3'b100);
        push_w(2'd1, 8'h20);
        push_cmd(3'b001);
        push_cmd(3'b101);
        push_rsp(8'h00, 1'b1, 1'b0);
        do_req(1'b0, 8'd0, 7'h10, 8'h55);
        wait_rsp();

        push_cmd(3'b100);
        push_w(2'd1, 8'h21);
        push_cmd(3'b001);
        push_cmd(3'b101);
        push_rsp(8'h00, 1'b1, 1'b0);
        do_req(1'b1, 8'd0, 7'h10, 8'h00);
        wait_rsp();

        full_write(8'd1, 7'h22, 8'h01, 1'b1);

        hang_start = 1'b1;
        push_w(2'd2, 8'h04);
        push_rsp(8'h00, 1'b0, 1'b1);
        push_w(2'd0, 8'hC0);
        do_req(1'b0, 8'd1, 7'h22, 8'h11);
        wait_rsp();
        check("timeout_latency", rsp_cyc - start_ack_cyc, 51);
        hang_start = 1'b0;
        full_write(8'd1, 7'h44, 8'h5A, 1'b1);

        push_w(2'd1, 8'h05);
        push_cmd(3'b110);
        push_rsp(8'h00, 1'b0, 1'b1);
        push_w(2'd0, 8'hC0);
        do_req(1'b0, 8'd5, 7'h22, 8'h12);
        wait_rsp();

        push_w(2'd1, 8'h00);
        push_cmd(3'b110);
        push_cmd(3'b100);
        push_w(2'd1, 8'h88);
        push_cmd(3'b001);
        push_w(2'd1, 8'h33);
        push_w(2'd2, 8'h01);
        data_cmd_seen = 1'b0;
        do_req(1'b0, 8'd0, 7'h44, 8'h33);
        n = 0;
        while (!data_cmd_seen && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("data_cmd_reached", {31'd0, data_cmd_seen}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_outs", {28'd0, cyc, stb, rsp_valid, req_ready}, 32'd0);
        check("ops_drained_at_rst", exp_ops.size(), 0);
        exp_ops.delete();
        push_w(2'd0, 8'hC0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ready();
        repeat (20) @(negedge clk);
        check("no_stale_rsp", rsp_seen, rsp_target);
        check("ops_left", exp_ops.size(), 0);
        check("rsps_left", exp_rsp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
